ldpc_3gpp_enc_p1_rbuf: RTL and testbench

Receiver-side ping-pong buffer for the p1 parity word stream (write/wstart/wdat) produced by the LDPC 3GPP encoder p1 stage. It collects one frame of `iwnum` words per bank and replays each completed frame to a downstream consumer over a valid/ready stream with sof/eof strobes. Writer and reader are decoupled, so the p2 stage or output buffer can stall without losing parity words.

---
 rtl/ldpc_3gpp_enc_p1_rbuf_pkg.sv | 19 +
 rtl/ldpc_3gpp_enc_p1_rbuf_skid.sv | 60 ++++++
 rtl/ldpc_3gpp_enc_p1_rbuf.sv | 186 ++++++++++++++++++
 tb/tb_ldpc_3gpp_enc_p1_rbuf.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_3gpp_enc_p1_rbuf_pkg.sv
// Shared types for the p1 parity receive buffer: stream strobes and read FSM states.
package ldpc_3gpp_enc_p1_rbuf_pkg;

    typedef struct packed {
        logic sof;
        logic eof;
        logic sop;
        logic eop;
    } strb_t;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_RUN   = 2'd1,
        RD_DRAIN = 2'd2
    } rd_state_t;

    localparam int unsigned cSKID_DEPTH = 2;

endpackage

// File: rtl/ldpc_3gpp_enc_p1_rbuf_skid.sv
// Two-entry valid/ready skid buffer with registered output and occupancy count.
module ldpc_3gpp_enc_rbuf_skid #(
    parameter int pW = 8
) (
    input  logic          iclk,
    input  logic          ireset,
    input  logic          iclkena,
    input  logic          ival,
    input  logic [pW-1:0] idat,
    input  logic          iready,
    output logic          oval,
    output logic [pW-1:0] odat,
    output logic [1:0]    ocnt
);

    logic [pW-1:0] tail;
    logic [1:0]    cnt;
    logic          pop;

    assign pop  = (cnt != 2'd0) & iready;
    assign oval = (cnt != 2'd0);
    assign ocnt = cnt;

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            odat <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (iclkena) begin
            case (cnt)
                2'd0: begin
                    if (ival) begin
                        odat <= idat;
                        cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({ival, pop})
                        2'b11: odat <= idat;
                        2'b10: begin
                            tail <= idat;
                            cnt  <= 2'd2;
                        end
                        2'b01: cnt <= 2'd0;
                        default: ;
                    endcase
                end
                default: begin
                    // a push into a full skid only happens together with a pop
                    if (pop) begin
                        odat <= tail;
                        if (ival) tail <= idat;
                        else      cnt  <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/ldpc_3gpp_enc_p1_rbuf.sv
// Ping-pong frame buffer for the p1 parity stream: two banks written frame-wise,
// each completed frame replayed over a valid/ready stream with sof/eof.
module ldpc_3gpp_enc_p1_rbuf
    import ldpc_3gpp_enc_p1_rbuf_pkg::*;
#(
    parameter int pADDR_W = 8,
    parameter int pDAT_W  = 8
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              iclkena,
    input  logic [pADDR_W:0]  iwnum,
    input  logic              iwrite,
    input  logic              iwstart,
    input  logic [pDAT_W-1:0] iwdat,
    output logic              owfull,
    output logic              ooverflow,
    input  logic              iready,
    output logic              oval,
    output strb_t             ostrb,
    output logic [pDAT_W-1:0] odat
);

    localparam int unsigned cDEPTH = 2**pADDR_W;

    typedef logic [pDAT_W-1:0]  dat_t;
    typedef logic [pADDR_W-1:0] addr_t;
    typedef logic [pADDR_W:0]   num_t;

    dat_t mem [2*cDEPTH];

    logic                 wb, rb;
    logic [1:0]           full, full_nxt;
    logic [1:0][pADDR_W:0] cnt;
    num_t                 wcnt, wnum;
    logic                 wact;

    logic  wr_en, commit, drop;
    addr_t wr_lo;
    num_t  commit_num;

    rd_state_t rd_state;
    addr_t     raddr, rd_lo;
    logic      rd_bank, rd_issue, rd_last, start, rel, pop, eof_acc, occ_ok, inflight;
    logic [2:0] occ;
    dat_t      rd_dat;
    strb_t     rd_meta;
    logic [1:0] skid_cnt;

    // ---------------- write side ----------------
    always_comb begin
        wr_en      = 1'b0;
        wr_lo      = '0;
        commit     = 1'b0;
        commit_num = '0;
        drop       = 1'b0;
        if (iwrite) begin
            if (full[wb]) begin
                drop = 1'b1;
            end else if (iwstart) begin
                wr_en = 1'b1;
                if (iwnum == num_t'(1)) begin
                    commit     = 1'b1;
                    commit_num = iwnum;
                end
            end else if (wact) begin
                wr_en = 1'b1;
                wr_lo = addr_t'(wcnt);
                if (wcnt + num_t'(1) == wnum) begin
                    commit     = 1'b1;
                    commit_num = wnum;
                end
            end else begin
                drop = 1'b1;
            end
        end
    end

    // release and commit never target the same bank: commit needs full[wb]=0, release needs full[rb]=1
    always_comb begin
        full_nxt = full;
        if (rel)    full_nxt[rb] = 1'b0;
        if (commit) full_nxt[wb] = 1'b1;
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            wb        <= 1'b0;
            full      <= '0;
            cnt       <= '0;
            wcnt      <= '0;
            wnum      <= '0;
            wact      <= 1'b0;
            owfull    <= 1'b0;
            ooverflow <= 1'b0;
        end else if (iclkena) begin
            ooverflow <= drop;
            full      <= full_nxt;
            owfull    <= &full_nxt;
            if (commit) begin
                cnt[wb] <= commit_num;
                wb      <= ~wb;
                wact    <= 1'b0;
            end else if (wr_en) begin
                if (iwstart) begin
                    wnum <= iwnum;
                    wcnt <= num_t'(1);
                    wact <= 1'b1;
                end else begin
                    wcnt <= wcnt + num_t'(1);
                end
            end
        end else begin
            ooverflow <= 1'b0;
        end
    end

    always_ff @(posedge iclk) begin
        if (iclkena) begin
            if (wr_en)    mem[{wb, wr_lo}] <= iwdat;
            if (rd_issue) rd_dat <= mem[{rd_bank, rd_lo}];
        end
    end

    // ---------------- read side ----------------
    // Credits count what will remain after this cycle's pop, so a full-rate stream never bubbles.
    // On eof acceptance the next committed bank is started in the same cycle for back-to-back frames.
    always_comb begin
        pop      = oval & iready;
        eof_acc  = pop & ostrb.eof;
        occ      = 3'(skid_cnt) + 3'(inflight) - 3'(pop);
        occ_ok   = (occ < 3'(cSKID_DEPTH));
        rel      = (rd_state == RD_DRAIN) & eof_acc;
        rd_bank  = rel ? ~rb : rb;
        start    = ((rd_state == RD_IDLE) | rel) & full[rd_bank] & occ_ok;
        rd_issue = start | ((rd_state == RD_RUN) & occ_ok);
        rd_lo    = start ? '0 : raddr;
        rd_last  = (num_t'(rd_lo) == cnt[rd_bank] - num_t'(1));
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            rd_state <= RD_IDLE;
            rb       <= 1'b0;
            raddr    <= '0;
            inflight <= 1'b0;
            rd_meta  <= '0;
        end else if (iclkena) begin
            inflight <= rd_issue;
            if (rd_issue)
                rd_meta <= '{sof: (rd_lo == '0), eof: rd_last, sop: 1'b0, eop: 1'b0};
            case (rd_state)
                RD_RUN: begin
                    if (occ_ok) begin
                        raddr <= raddr + addr_t'(1);
                        if (rd_last) rd_state <= RD_DRAIN;
                    end
                end
                default: begin
                    if (rel) rb <= ~rb;
                    if (start) begin
                        raddr    <= addr_t'(1);
                        rd_state <= rd_last ? RD_DRAIN : RD_RUN;
                    end else if (rel) begin
                        rd_state <= RD_IDLE;
                    end
                end
            endcase
        end
    end

    ldpc_3gpp_enc_rbuf_skid #(
        .pW($bits(strb_t) + pDAT_W)
    ) u_skid (
        .iclk    (iclk),
        .ireset  (ireset),
        .iclkena (iclkena),
        .ival    (inflight),
        .idat    ({rd_meta, rd_dat}),
        .iready  (iready),
        .oval    (oval),
        .odat    ({ostrb, odat}),
        .ocnt    (skid_cnt)
    );

endmodule

// File: tb/tb_ldpc_3gpp_enc_p1_rbuf.sv
// Directed bench for the p1 parity ping-pong buffer with an output monitor and stall checks.
module tb_ldpc_3gpp_enc_p1_rbuf;
    import ldpc_3gpp_enc_p1_rbuf_pkg::*;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          iclk = 1'b0;
    logic          ireset, iclkena, iwrite, iwstart, iready;
    logic [AW:0]   iwnum;
    logic [DW-1:0] iwdat, odat;
    logic          owfull, ooverflow, oval;
    strb_t         ostrb;

    int          n_chk = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;

    logic [9:0]  got_q[$];
    int unsigned got_cyc[$];
    logic [9:0]  exp_q[$];

    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_dat;
    strb_t         prev_strb;

    ldpc_3gpp_enc_p1_rbuf #(
        .pADDR_W (AW),
        .pDAT_W  (DW)
    ) dut (
        .iclk      (iclk),
        .ireset    (ireset),
        .iclkena   (iclkena),
        .iwnum     (iwnum),
        .iwrite    (iwrite),
        .iwstart   (iwstart),
        .iwdat     (iwdat),
        .owfull    (owfull),
        .ooverflow (ooverflow),
        .iready    (iready),
        .oval      (oval),
        .ostrb     (ostrb),
        .odat      (odat)
    );

    always #5 iclk = ~iclk;

    always @(posedge iclk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: records accepted words and checks that stalled outputs hold.
    always @(negedge iclk) begin
        if (ireset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_oval", 32'(oval), 32'd1);
                chk("stall_odat", 32'(odat), 32'(prev_dat));
                chk("stall_strb", 32'(ostrb), 32'(prev_strb));
            end
            if (iclkena && oval && iready) begin
                got_q.push_back({ostrb.sof, ostrb.eof, odat});
                got_cyc.push_back(cyc);
            end
            prev_stall = oval && !(iready && iclkena);
            prev_dat   = odat;
            prev_strb  = ostrb;
        end
    end

    function automatic logic [9:0] w(input logic sof, input logic eof, input logic [7:0] d);
        return {sof, eof, d};
    endfunction

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic wr(input logic st, input logic [7:0] d);
        iwrite  = 1'b1;
        iwstart = st;
        iwdat   = d;
        tick();
        iwrite  = 1'b0;
        iwstart = 1'b0;
    endtask

    task automatic expect_all(input string tag, input int unsigned budget, input bit consec);
        int unsigned t = 0;
        int unsigned k = 0;
        int unsigned c0;
        while (got_q.size() < exp_q.size() && t < budget) begin
            tick();
            t++;
        end
        if (got_q.size() < exp_q.size())
            chk({tag, "_timeout"}, 32'(got_q.size()), 32'(exp_q.size()));
        c0 = (got_cyc.size() > 0) ? got_cyc[0] : 0;
        while (exp_q.size() > 0) begin
            if (got_q.size() > 0) begin
                chk($sformatf("%s[%0d]", tag, k), 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
                if (consec)
                    chk($sformatf("%s_gap[%0d]", tag, k), got_cyc.pop_front() - c0, k);
                else
                    void'(got_cyc.pop_front());
            end else begin
                void'(exp_q.pop_front());
            end
            k++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ireset  = 1'b1;
        iclkena = 1'b1;
        iwrite  = 1'b0;
        iwstart = 1'b0;
        iwdat   = '0;
        iwnum   = 9'd4;
        iready  = 1'b0;
        #1;
        tick();
        tick();
        chk("rst_oval", 32'(oval), 0);
        chk("rst_strb", 32'(ostrb), 0);
        chk("rst_odat", 32'(odat), 0);
        chk("rst_owfull", 32'(owfull), 0);
        chk("rst_ovf", 32'(ooverflow), 0);
        ireset = 1'b0;
        tick();

        // 1: 4-word frame, latency and full-rate output
        iwnum  = 9'd4;
        iready = 1'b1;
        for (int i = 0; i < 4; i++) wr(i == 0, 8'hA0 + 8'(i));
        chk("t1_oval_N", 32'(oval), 0);
        tick();
        chk("t1_oval_N1", 32'(oval), 0);
        tick();
        chk("t1_oval_N2", 32'(oval), 1);
        chk("t1_sof_N2", 32'(ostrb.sof), 1);
        chk("t1_dat_N2", 32'(odat), 32'hA0);
        for (int i = 0; i < 4; i++) exp_q.push_back(w(i == 0, i == 3, 8'hA0 + 8'(i)));
        expect_all("t1", 20, 1'b1);

        // 2: single-word frame, then a write without iwstart is dropped
        iwnum = 9'd1;
        wr(1'b1, 8'h5A);
        exp_q.push_back(w(1'b1, 1'b1, 8'h5A));
        expect_all("t2", 20, 1'b0);
        wr(1'b0, 8'hE0);
        chk("t2_ovf_nostart", 32'(ooverflow), 1);
        tick();
        chk("t2_ovf_clear", 32'(ooverflow), 0);
        repeat (4) tick();
        chk("t2_extra", 32'(got_q.size()), 0);

        // 3: both banks fill while stalled, third write dropped, order kept
        iready = 1'b0;
        iwnum  = 9'd3;
        for (int i = 0; i < 3; i++) wr(i == 0, 8'hB0 + 8'(i));
        tick();
        chk("t3_owfull_one", 32'(owfull), 0);
        for (int i = 0; i < 3; i++) wr(i == 0, 8'hC0 + 8'(i));
        tick();
        chk("t3_owfull", 32'(owfull), 1);
        chk("t3_ovf_pre", 32'(ooverflow), 0);
        wr(1'b1, 8'hD0);
        chk("t3_ovf", 32'(ooverflow), 1);
        tick();
        chk("t3_ovf_clear", 32'(ooverflow), 0);
        chk("t3_stalled", 32'(got_q.size()), 0);
        iready = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(w(i == 0, i == 2, 8'hB0 + 8'(i)));
        for (int i = 0; i < 3; i++) exp_q.push_back(w(i == 0, i == 2, 8'hC0 + 8'(i)));
        expect_all("t3", 50, 1'b0);
        repeat (2) tick();
        chk("t3_owfull_rel", 32'(owfull), 0);

        // 4: iwstart mid-frame discards the partial frame
        iwnum = 9'd4;
        wr(1'b1, 8'h01);
        wr(1'b0, 8'h02);
        for (int i = 0; i < 4; i++) wr(i == 0, 8'h10 + 8'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back(w(i == 0, i == 3, 8'h10 + 8'(i)));
        expect_all("t4", 20, 1'b0);
        repeat (4) tick();
        chk("t4_extra", 32'(got_q.size()), 0);

        // 5: 256-word frame with random iready and iclkena gaps
        iwnum = 9'd256;
        begin
            int unsigned i = 0;
            int unsigned t = 0;
            while (i < 256) begin
                iready  = 1'($urandom_range(0, 1));
                iclkena = ($urandom_range(0, 7) != 0);
                iwrite  = 1'b1;
                iwstart = (i == 0);
                iwdat   = 8'(i) ^ 8'h5C;
                @(posedge iclk);
                if (iclkena) i++;
                #1;
            end
            iwrite  = 1'b0;
            iwstart = 1'b0;
            while (got_q.size() < 256 && t < 3000) begin
                iready  = 1'($urandom_range(0, 1));
                iclkena = ($urandom_range(0, 7) != 0);
                tick();
                t++;
            end
        end
        iclkena = 1'b1;
        iready  = 1'b1;
        for (int i = 0; i < 256; i++) exp_q.push_back(w(i == 0, i == 255, 8'(i) ^ 8'h5C));
        expect_all("t5", 100, 1'b0);
        repeat (4) tick();
        chk("t5_extra", 32'(got_q.size()), 0);

        // 6: reset while a frame is being presented
        iready = 1'b0;
        iwnum  = 9'd4;
        for (int i = 0; i < 4; i++) wr(i == 0, 8'hF0 + 8'(i));
        tick();
        tick();
        chk("t6_oval_pre", 32'(oval), 1);
        #2 ireset = 1'b1;
        #1;
        chk("t6_oval_rst", 32'(oval), 0);
        chk("t6_strb_rst", 32'(ostrb), 0);
        chk("t6_odat_rst", 32'(odat), 0);
        tick();
        ireset = 1'b0;
        got_q.delete();
        got_cyc.delete();
        tick();
        iready = 1'b1;
        for (int i = 0; i < 4; i++) wr(i == 0, 8'h30 + 8'(i));
        for (int i = 0; i < 4; i++) exp_q.push_back(w(i == 0, i == 3, 8'h30 + 8'(i)));
        expect_all("t6", 20, 1'b1);
        repeat (4) tick();
        chk("t6_extra", 32'(got_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

endmodule
